// File: rtl/dma_buf_sequencer_if.sv
// Handshake/status bundle between the DMA buffer sequencer, its control
// registers, the acquisition FIFO level and the TLP transmit engine.
interface dma_buf_sequencer_if;
    logic        dma_enable;
    logic [24:0] dma_size;
    logic [15:0] fifo_words;
    logic        tlp_req;
    logic        tlp_ack;
    logic        tlp_done;
    logic [24:0] burst_offset;
    logic [3:0]  dma_curr_buf;
    logic        buf_done;
    logic [31:0] buf_count;
    logic        busy;
    logic        err;

    modport slave (
        input  dma_enable, dma_size, fifo_words, tlp_ack, tlp_done,
        output tlp_req, burst_offset, dma_curr_buf, buf_done, buf_count, busy, err
    );

    modport master (
        output dma_enable, dma_size, fifo_words, tlp_ack, tlp_done,
        input  tlp_req, burst_offset, dma_curr_buf, buf_done, buf_count, busy, err
    );
endinterface

// File: rtl/dma_buf_sequencer.sv
// Walks the host buffer ring, splitting each buffer into TX bursts.
// Optional watchdog on the TX handshake: define DMA_TIMEOUT_EN.
module dma_buf_sequencer #(
    parameter int NUM_BUFS    = 16,
    parameter int BURST_BYTES = 128,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 trn_clk,
    input  logic                 pio_reset_n,
    dma_buf_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, WAIT_DONE, NEXT} state_t;

    localparam logic [24:0] STEP     = 25'(BURST_BYTES / 128);
    localparam logic [15:0] FIFO_THR = 16'(BURST_BYTES / 4);
    localparam logic [3:0]  LAST_BUF = 4'(NUM_BUFS - 1);

    state_t      r_state;
    logic        r_en_d;
    logic        r_tlp_req;
    logic        r_buf_done;
    logic        r_err;
    logic [24:0] r_offset;
    logic [3:0]  r_curr_buf;
    logic [31:0] r_buf_count;

    logic        w_en_rise;
    logic [24:0] w_offset_nxt;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_en_rise    = bus.dma_enable & ~r_en_d;
    assign w_offset_nxt = r_offset + STEP;

`ifdef DMA_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_wdog;
    logic        w_wdog_stay;

    // Counter runs only while the handshake state is held; any transition clears it.
    assign w_wdog_stay = (r_state == REQ       && !bus.tlp_ack) ||
                         (r_state == WAIT_DONE && !bus.tlp_done);
`endif

    always_ff @(posedge trn_clk or negedge pio_reset_n) begin
        if (!pio_reset_n) begin
            r_state     <= IDLE;
            r_en_d      <= 1'b0;
            r_tlp_req   <= 1'b0;
            r_buf_done  <= 1'b0;
            r_err       <= 1'b0;
            r_offset    <= '0;
            r_curr_buf  <= '0;
            r_buf_count <= '0;
`ifdef DMA_TIMEOUT_EN
            r_wdog      <= '0;
`endif
        end else begin
            r_en_d     <= bus.dma_enable;
            r_buf_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_en_rise) begin
                        r_offset    <= '0;
                        r_curr_buf  <= '0;
                        r_buf_count <= '0;
                        if (bus.dma_size == 25'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (!bus.dma_enable)
                        r_state <= IDLE;
                    else if (bus.fifo_words >= FIFO_THR)
                        r_state <= REQ;
                end
                REQ: begin
                    if (bus.tlp_ack) begin
                        r_tlp_req <= 1'b0;
                        r_state   <= bus.tlp_done ? NEXT : WAIT_DONE;
                    end else begin
                        r_tlp_req <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tlp_done)
                        r_state <= NEXT;
                end
                NEXT: begin
                    // >= rather than == so a shrunk dma_size still closes the buffer.
                    if (w_offset_nxt >= bus.dma_size) begin
                        r_offset    <= '0;
                        r_curr_buf  <= (r_curr_buf == LAST_BUF) ? 4'd0 : r_curr_buf + 4'd1;
                        r_buf_count <= sat_inc32(r_buf_count);
                        r_buf_done  <= 1'b1;
                    end else begin
                        r_offset <= w_offset_nxt;
                    end
                    r_state <= WAIT_DATA;
                end
                default: r_state <= IDLE;
            endcase
`ifdef DMA_TIMEOUT_EN
            if (w_wdog_stay) begin
                if (r_wdog == WDOG_LAST) begin
                    r_err     <= 1'b1;
                    r_tlp_req <= 1'b0;
                    r_state   <= IDLE;
                    r_wdog    <= '0;
                end else begin
                    r_wdog <= r_wdog + 16'd1;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

    assign bus.tlp_req      = r_tlp_req;
    assign bus.burst_offset = r_offset;
    assign bus.dma_curr_buf = r_curr_buf;
    assign bus.buf_done     = r_buf_done;
    assign bus.buf_count    = r_buf_count;
    assign bus.busy         = (r_state != IDLE);
    assign bus.err          = r_err;

endmodule

// File: tb/tb_dma_buf_sequencer.sv
// Directed bench for dma_buf_sequencer with a queue-based scoreboard on burst
// requests and buffer-completion pulses.
module tb_dma_buf_sequencer;

    typedef struct packed {logic [24:0] off; logic [3:0] cbuf;} req_t;
    typedef struct packed {logic [3:0] cbuf; logic [31:0] cnt;} done_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    req_t  req_q[$];
    done_t done_q[$];
    logic  prev_req;

    dma_buf_sequencer_if bif();

    dma_buf_sequencer #(.NUM_BUFS(4), .BURST_BYTES(128), .TIMEOUT_CYC(100)) dut (
        .trn_clk    (clk),
        .pio_reset_n(rst_n),
        .bus        (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bif.tlp_req) break;
        end
        if (!bif.tlp_req) begin
            total++;
            bad++;
            $display("FAIL wait_req: tlp_req got 0 expected 1 within 50 cycles");
        end
    endtask

    // Ack 3 cycles after req, done 2 cycles later; optionally starve the FIFO afterwards.
    task automatic burst(input logic last);
        wait_req();
        step(3);
        bif.tlp_ack = 1'b1;
        step();
        bif.tlp_ack = 1'b0;
        if (last) bif.fifo_words = 16'd0;
        step();
        bif.tlp_done = 1'b1;
        step();
        bif.tlp_done = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bif.tlp_req && !prev_req) begin
            total++;
            if (req_q.size() == 0) begin
                bad++;
                $display("FAIL req_unexpected: got off=%0d buf=%0d expected no request",
                         bif.burst_offset, bif.dma_curr_buf);
            end else begin
                req_t e;
                e = req_q.pop_front();
                if (bif.burst_offset !== e.off || bif.dma_curr_buf !== e.cbuf) begin
                    bad++;
                    $display("FAIL req: got off=%0d buf=%0d expected off=%0d buf=%0d",
                             bif.burst_offset, bif.dma_curr_buf, e.off, e.cbuf);
                end
            end
        end
        prev_req = bif.tlp_req;
        if (bif.buf_done) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got buf=%0d cnt=%0d expected no pulse",
                         bif.dma_curr_buf, bif.buf_count);
            end else begin
                done_t d;
                d = done_q.pop_front();
                if (bif.dma_curr_buf !== d.cbuf || bif.buf_count !== d.cnt) begin
                    bad++;
                    $display("FAIL done: got buf=%0d cnt=%0d expected buf=%0d cnt=%0d",
                             bif.dma_curr_buf, bif.buf_count, d.cbuf, d.cnt);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        prev_req = 1'b0;
        rst_n = 1'b0;
        bif.dma_enable = 1'b0;
        bif.dma_size   = 25'd0;
        bif.fifo_words = 16'd0;
        bif.tlp_ack    = 1'b0;
        bif.tlp_done   = 1'b0;
        step(3);
        chk("rst_req",   {31'd0, bif.tlp_req}, 32'd0);
        chk("rst_off",   {7'd0, bif.burst_offset}, 32'd0);
        chk("rst_buf",   {28'd0, bif.dma_curr_buf}, 32'd0);
        chk("rst_done",  {31'd0, bif.buf_done}, 32'd0);
        chk("rst_cnt",   bif.buf_count, 32'd0);
        chk("rst_busy",  {31'd0, bif.busy}, 32'd0);
        chk("rst_err",   {31'd0, bif.err}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Normal fill: 512-byte buffer, four bursts
        for (int i = 0; i < 4; i++) req_q.push_back('{off: 25'(i), cbuf: 4'd0});
        done_q.push_back('{cbuf: 4'd1, cnt: 32'd1});
        bif.dma_size   = 25'd4;
        bif.fifo_words = 16'd1000;
        bif.dma_enable = 1'b1;
        for (int i = 0; i < 4; i++) burst(i == 3);
        step(4);
        chk("fill_buf",  {28'd0, bif.dma_curr_buf}, 32'd1);
        chk("fill_cnt",  bif.buf_count, 32'd1);
        chk("fill_off",  {7'd0, bif.burst_offset}, 32'd0);
        bif.dma_enable = 1'b0;
        step(3);
        chk("fill_idle", {31'd0, bif.busy}, 32'd0);

        // Ring wrap over 4 buffers, five 128-byte buffers
        req_q.push_back('{off: 25'd0, cbuf: 4'd0});
        req_q.push_back('{off: 25'd0, cbuf: 4'd1});
        req_q.push_back('{off: 25'd0, cbuf: 4'd2});
        req_q.push_back('{off: 25'd0, cbuf: 4'd3});
        req_q.push_back('{off: 25'd0, cbuf: 4'd0});
        done_q.push_back('{cbuf: 4'd1, cnt: 32'd1});
        done_q.push_back('{cbuf: 4'd2, cnt: 32'd2});
        done_q.push_back('{cbuf: 4'd3, cnt: 32'd3});
        done_q.push_back('{cbuf: 4'd0, cnt: 32'd4});
        done_q.push_back('{cbuf: 4'd1, cnt: 32'd5});
        bif.dma_size   = 25'd1;
        bif.fifo_words = 16'd1000;
        bif.dma_enable = 1'b1;
        for (int i = 0; i < 5; i++) burst(i == 4);
        step(4);
        chk("ring_buf", {28'd0, bif.dma_curr_buf}, 32'd1);
        chk("ring_cnt", bif.buf_count, 32'd5);
        bif.dma_enable = 1'b0;
        step(3);

        // Starvation, then restart clears ring state
        bif.dma_size   = 25'd4;
        bif.fifo_words = 16'd31;
        bif.dma_enable = 1'b1;
        step(10);
        chk("starve_req",  {31'd0, bif.tlp_req}, 32'd0);
        chk("starve_busy", {31'd0, bif.busy}, 32'd1);
        chk("restart_buf", {28'd0, bif.dma_curr_buf}, 32'd0);
        chk("restart_cnt", bif.buf_count, 32'd0);
        req_q.push_back('{off: 25'd0, cbuf: 4'd0});
        bif.fifo_words = 16'd32;
        @(negedge clk);
        chk("thr_req_c0", {31'd0, bif.tlp_req}, 32'd0);
        @(negedge clk);
        chk("thr_req_c1", {31'd0, bif.tlp_req}, 32'd0);
        @(negedge clk);
        chk("thr_req_c2", {31'd0, bif.tlp_req}, 32'd1);

        // Stop while waiting for done: burst still completes
        step();
        bif.tlp_ack = 1'b1;
        step();
        bif.tlp_ack = 1'b0;
        bif.dma_enable = 1'b0;
        step(2);
        bif.tlp_done = 1'b1;
        step();
        bif.tlp_done = 1'b0;
        @(negedge clk);
        chk("stop_busy_next", {31'd0, bif.busy}, 32'd1);
        @(negedge clk);
        chk("stop_busy_wd",   {31'd0, bif.busy}, 32'd1);
        @(negedge clk);
        chk("stop_busy_idle", {31'd0, bif.busy}, 32'd0);
        chk("stop_off",       {7'd0, bif.burst_offset}, 32'd1);

        // Zero size at start
        bif.dma_size   = 25'd0;
        bif.fifo_words = 16'd1000;
        bif.dma_enable = 1'b1;
        step(5);
        chk("zero_err",  {31'd0, bif.err}, 32'd1);
        chk("zero_busy", {31'd0, bif.busy}, 32'd0);
        chk("zero_off",  {7'd0, bif.burst_offset}, 32'd0);
        bif.dma_enable = 1'b0;
        step(2);

        // Ack and done together: one advance only
        req_q.push_back('{off: 25'd0, cbuf: 4'd0});
        bif.dma_size   = 25'd4;
        bif.dma_enable = 1'b1;
        wait_req();
        step(2);
        bif.tlp_ack  = 1'b1;
        bif.tlp_done = 1'b1;
        bif.fifo_words = 16'd0;
        step();
        bif.tlp_ack  = 1'b0;
        bif.tlp_done = 1'b0;
        step(4);
        chk("same_off",  {7'd0, bif.burst_offset}, 32'd1);
        chk("same_err",  {31'd0, bif.err}, 32'd0);
        chk("same_busy", {31'd0, bif.busy}, 32'd1);
        chk("same_cnt",  bif.buf_count, 32'd0);

        // Async reset while requesting
        req_q.push_back('{off: 25'd1, cbuf: 4'd0});
        bif.fifo_words = 16'd32;
        wait_req();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  {31'd0, bif.tlp_req}, 32'd0);
        chk("arst_off",  {7'd0, bif.burst_offset}, 32'd0);
        chk("arst_busy", {31'd0, bif.busy}, 32'd0);
        chk("arst_err",  {31'd0, bif.err}, 32'd0);
        bif.dma_enable = 1'b0;
        bif.fifo_words = 16'd0;
        step(2);
        rst_n = 1'b1;
        step(2);

`ifdef DMA_TIMEOUT_EN
        // Withheld done: watchdog fires after 100 cycles in WAIT_DONE
        req_q.push_back('{off: 25'd0, cbuf: 4'd0});
        bif.dma_size   = 25'd4;
        bif.fifo_words = 16'd32;
        bif.dma_enable = 1'b1;
        wait_req();
        step();
        bif.tlp_ack = 1'b1;
        bif.fifo_words = 16'd0;
        step();
        bif.tlp_ack = 1'b0;
        repeat (100) @(negedge clk);
        chk("wdog_busy_before", {31'd0, bif.busy}, 32'd1);
        @(negedge clk);
        chk("wdog_busy", {31'd0, bif.busy}, 32'd0);
        chk("wdog_err",  {31'd0, bif.err}, 32'd1);
        chk("wdog_buf",  {28'd0, bif.dma_curr_buf}, 32'd0);
        chk("wdog_req",  {31'd0, bif.tlp_req}, 32'd0);
        bif.dma_enable = 1'b0;
        step(2);
`endif

        step(3);
        chk("req_q_empty",  req_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_buf_sequencer.md
Name: dma_buf_sequencer

Overview:
- Sequences host DMA across the ring of NUM_BUFS host buffers programmed through the BAR1 DMA_BUFF_x registers.
- Drives dma_curr_buf, which selects the host base address in the register block.
- Splits each buffer of dma_size bytes into fixed-size write bursts, handshaking each burst with the TLP transmit engine.
- Raises a per-buffer completion pulse for the interrupt logic; sits between the acquisition FIFO, the BAR1 register block and the TX engine.

Parameters:
- NUM_BUFS, 16, number of ring buffers used (2..16); dma_curr_buf wraps at NUM_BUFS-1.
- BURST_BYTES, 128, bytes per TLP burst; power of 2, minimum 128.
- TIMEOUT_CYC, 65535, watchdog limit in trn_clk cycles (used only with DMA_TIMEOUT_EN).

Ports:
- trn_clk  in  1  PCIe user clock; all logic is on its rising edge.
- pio_reset_n  in  1  asynchronous active-low reset.
- dma_enable  in  1  level from a COMMAND_r bit; its rising edge starts a new acquisition.
- dma_size  in  25  [31:7] bytes per buffer; bits 6:0 are implied zero.
- fifo_words  in  16  32-bit words available in the acquisition FIFO.
- tlp_req  out  1  burst request to the TX engine.
- tlp_ack  in  1  one-cycle pulse: burst accepted.
- tlp_done  in  1  one-cycle pulse: burst fully transmitted.
- burst_offset  out  25  [31:7] byte offset of the current burst within the buffer.
- dma_curr_buf  out  4  current ring buffer index.
- buf_done  out  1  one-cycle pulse when a buffer completes.
- buf_count  out  32  buffers completed since the last start.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky error flag.

Behaviour:
- Clock and reset: single clock trn_clk; pio_reset_n is an asynchronous active-low reset.
- Reset values: tlp_req=0, burst_offset=0, dma_curr_buf=0, buf_done=0, buf_count=0, busy=0, err=0; state=IDLE.
- States: IDLE, WAIT_DATA, REQ, WAIT_DONE, NEXT.
- IDLE: on a dma_enable rising edge, clear burst_offset, dma_curr_buf, buf_count and err, then go to WAIT_DATA.
  - If dma_size==0 at that edge, set err and stay in IDLE.
- WAIT_DATA:
  - If dma_enable=0, go to IDLE.
  - Else if fifo_words >= BURST_BYTES/4, go to REQ. tlp_req is asserted in the cycle after entry.
- REQ: hold tlp_req=1 until tlp_ack; on ack drop tlp_req the next cycle and go to WAIT_DONE.
  - If tlp_ack and tlp_done arrive in the same cycle, treat it as done and go straight to NEXT.
- WAIT_DONE: on tlp_done go to NEXT.
  - tlp_done outside WAIT_DONE/REQ is ignored.
  - tlp_ack outside REQ is ignored.
- NEXT (one cycle):
  - Compute offset_nxt = burst_offset + BURST_BYTES/128 in 25-bit arithmetic.
  - If offset_nxt >= dma_size:
    - burst_offset <= 0.
    - dma_curr_buf <= (dma_curr_buf==NUM_BUFS-1) ? 0 : dma_curr_buf+1.
    - buf_count <= buf_count+1, saturating at 32'hFFFFFFFF.
    - buf_done pulses 1 for exactly this cycle.
  - Else burst_offset <= offset_nxt.
  - Then go to WAIT_DATA.
- Stopping: dma_enable falling mid-burst does not abort.
  - The current burst completes through NEXT, including any buffer advance.
  - WAIT_DATA then returns to IDLE.
- dma_size changes: a change during operation takes effect at the next NEXT comparison; burst_offset is never left beyond dma_size.
- Reset mid-burst: immediate return to reset values; the TX engine is responsible for discarding any in-flight TLP.
- Register timing: burst_offset and dma_curr_buf are stable from REQ entry until NEXT, so the address stays constant while tlp_req is high.

Optional Feature:
- Macro: DMA_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles spent in REQ or WAIT_DONE and clears on every state change.
  - On reaching TIMEOUT_CYC: err=1, tlp_req=0, go to IDLE. dma_curr_buf and buf_count are kept for host diagnosis.
- Undefined: no watchdog. err is set only by a zero dma_size at start, and REQ/WAIT_DONE wait indefinitely.

Test Plan:
- Normal fill: dma_size=512 (4 bursts), fifo_words=1000, ack and done given 3 cycles after each req.
  - Required: burst_offset sequence 0,1,2,3.
  - Required: buf_done one pulse, dma_curr_buf 0->1, buf_count=1.
- Ring wrap: NUM_BUFS=4, dma_size=128, run 5 buffers.
  - Required: dma_curr_buf sequence 0,1,2,3,0,1; buf_count=5.
- Starvation: fifo_words=31.
  - Required: tlp_req stays 0, busy=1.
  - Raise fifo_words to 32: tlp_req goes high 2 cycles later.
- Stop mid-burst: drop dma_enable while in WAIT_DONE.
  - Required: burst completes, busy=0 one cycle after leaving WAIT_DATA.
  - Then restart: dma_curr_buf=0, buf_count=0.
- Edge cases:
  - dma_size=0 at start: err=1, no tlp_req.
  - tlp_ack and tlp_done in the same cycle: a single offset advance.
  - Async reset asserted in REQ: all outputs at reset values within the same cycle.
- With DMA_TIMEOUT_EN, TIMEOUT_CYC=100: withhold tlp_done.
  - Required: err=1 and state IDLE after 100 cycles in WAIT_DONE; dma_curr_buf unchanged.
